// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
//   Requester-side bundle for the two-port ROM burst reader.
//   Per requester n (0/1):
//     reqn   level request, held by the client until it sees ackn
//     addrn  burst start address, sampled together with reqn
//     lenn   burst length minus one, sampled together with reqn
//     ackn   one-cycle pulse, the request has been accepted
//     datan  registered read data
//     validn datan carries a burst word this cycle
//     donen  one-cycle pulse on the last valid word of a burst
//   Modports: slave = the arbiter, master = the client side.
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
);
  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [LEN_WIDTH-1:0]  len0;
  logic [LEN_WIDTH-1:0]  len1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  valid0;
  logic                  valid1;
  logic                  done0;
  logic                  done1;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1,
    output ack0, ack1, data0, data1, valid0, valid1, done0, done1
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1,
    input  ack0, ack1, data0, data1, valid0, valid1, done0, done1
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Two-port burst read controller in front of a 16x4 synchronous ROM.
//   Arbitrates round-robin between two requesters, drives the ROM
//   enable/address pins for len+1 consecutive (wrapping) addresses and
//   returns each word to the granted requester with valid, plus a done
//   pulse on the last word.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          requester bundle (rom_arbiter_if.slave)
//   rom_enable   ROM enable
//   rom_address  ROM address (holds last issued value while idle)
//   rom_data     ROM read data, valid one edge after enable+address
//   dbg_state    current FSM state (0=IDLE, 1=BURST, 2=DRAIN)
//
// Handshake: a client raises reqN with addrN/lenN stable and keeps all
// three unchanged until it observes ackN=1. The arbiter only samples
// requests while IDLE; a request seen during BURST/DRAIN simply waits.
// Words arrive as validN strobes with no backpressure; doneN marks the
// final word of the burst in the same cycle as its validN.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rom_arbiter_if.slave          bus,
  output logic                  rom_enable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;        // 1 = requester 1 preferred on a tie
  logic                  owner_q, owner_d;    // requester being served
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;    // words left after the current one
  logic                  drain_q, drain_d;    // second DRAIN cycle marker
  logic                  rom_enable_q, rom_enable_d;
  logic                  rd_pend_q, rd_pend_d; // ROM output holds a burst word
  logic                  rd_last_q, rd_last_d; // ...and it is the final one
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  valid0_q, valid0_d;
  logic                  valid1_q, valid1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;

  logic                  grant1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cur_addr_d   = cur_addr_q;
    count_d      = count_q;
    drain_d      = drain_q;
    rom_enable_d = rom_enable_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    valid0_d     = 1'b0;
    valid1_d     = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    data0_d      = data0_q;
    data1_d      = data1_q;
    grant1       = 1'b0;

    // Read pipeline: an address presented this cycle is captured by the
    // ROM at the coming edge; its data is registered one edge later.
    rd_pend_d = rom_enable_q;
    rd_last_d = (state_q == S_BURST) && (count_q == '0);

    if (rd_pend_q) begin
      if (owner_q) begin
        data1_d  = rom_data;
        valid1_d = 1'b1;
        done1_d  = rd_last_q;
      end else begin
        data0_d  = rom_data;
        valid0_d = 1'b1;
        done0_d  = rd_last_q;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Tie goes to the pointer; a lone request always wins.
          grant1       = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
          owner_d      = grant1;
          ptr_d        = ~grant1;
          ack0_d       = ~grant1;
          ack1_d       = grant1;
          cur_addr_d   = grant1 ? bus.addr1 : bus.addr0;
          count_d      = grant1 ? bus.len1 : bus.len0;
          rom_enable_d = 1'b1;
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        if (count_q == '0) begin
          // Last word is on the pins now; address is left where it is.
          rom_enable_d = 1'b0;
          drain_d      = 1'b0;
          state_d      = S_DRAIN;
        end else begin
          cur_addr_d = cur_addr_q + 1'b1;  // natural wrap 15 -> 0
          count_d    = count_q - 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      cur_addr_q   <= '0;
      count_q      <= '0;
      drain_q      <= 1'b0;
      rom_enable_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cur_addr_q   <= cur_addr_d;
      count_q      <= count_d;
      drain_q      <= drain_d;
      rom_enable_q <= rom_enable_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign rom_enable  = rom_enable_q;
  assign rom_address = cur_addr_q;
  assign dbg_state   = state_q;

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.data0  = data0_q;
  assign bus.data1  = data1_q;

endmodule
